// File: rtl/hazard_ctrl.sv
// Load-use hazard controller: stalls for LOAD_LAT cycles per load-use hazard,
// flushes on taken branches, freezes on memory busy, and counts stall cycles.
module hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_ifid,
  input  logic [REG_W-1:0] rs2_ifid,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic [REG_W-1:0] rd_idex,
  input  logic             memread_idex,
  input  logic             branch_taken_ex,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             hz;

  assign hz = memread_idex && (rd_idex != '0) &&
              ((use_rs1 && (rs1_ifid == rd_idex)) ||
               (use_rs2 && (rs2_ifid == rd_idex)));

  always_comb begin
    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_stall    = 1'b0;
    ifid_hold   = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    freeze      = mem_busy;

    // Reset masks the stall/flush outputs at once, before the async clear lands.
    if (!rst_n) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (mem_busy) begin
      state_d = state_q;
    end else if (branch_taken_ex) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = IDLE;
      cnt_d      = '0;
    end else if (state_q == STALL) begin
      pc_stall    = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
      cnt_d       = cnt_q - 3'd1;
      if (cnt_q == 3'd1) state_d = IDLE;
    end else if (hz) begin
      pc_stall    = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d = STALL;
        cnt_d   = LAT_M1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three instances (LOAD_LAT 1, 3, 4/CNT_W 4)
// share inputs; directed steps push hand-computed expectations, a monitor compares.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1_ifid = '0, rs2_ifid = '0, rd_idex = '0;
  logic       use_rs1 = 1'b0, use_rs2 = 1'b0, memread_idex = 1'b0;
  logic       branch_taken_ex = 1'b0, mem_busy = 1'b0;

  always #5 clk = ~clk;

  logic        pc_stall [3], ifid_hold [3], idex_bubble [3];
  logic        ifid_flush [3], idex_flush [3], freeze [3];
  logic [15:0] sc [3];
  logic [15:0] sc1, sc3;
  logic [3:0]  sc4;

  assign sc[0] = sc1;
  assign sc[1] = sc3;
  assign sc[2] = {12'd0, sc4};

  hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .rd_idex(rd_idex), .memread_idex(memread_idex),
    .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
    .pc_stall(pc_stall[0]), .ifid_hold(ifid_hold[0]), .idex_bubble(idex_bubble[0]),
    .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]), .freeze(freeze[0]),
    .stall_cycles(sc1));

  hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .rd_idex(rd_idex), .memread_idex(memread_idex),
    .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
    .pc_stall(pc_stall[1]), .ifid_hold(ifid_hold[1]), .idex_bubble(idex_bubble[1]),
    .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]), .freeze(freeze[1]),
    .stall_cycles(sc3));

  hazard_ctrl #(.REG_W(5), .LOAD_LAT(4), .CNT_W(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .rd_idex(rd_idex), .memread_idex(memread_idex),
    .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
    .pc_stall(pc_stall[2]), .ifid_hold(ifid_hold[2]), .idex_bubble(idex_bubble[2]),
    .ifid_flush(ifid_flush[2]), .idex_flush(idex_flush[2]), .freeze(freeze[2]),
    .stall_cycles(sc4));

  typedef struct {
    int          sel;
    string       tag;
    logic        stall;
    logic        flush;
    logic        frz;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int   s;
      e = exp_q.pop_front();
      s = e.sel;
      check({e.tag, ".pc_stall"},    16'(pc_stall[s]),    16'(e.stall));
      check({e.tag, ".ifid_hold"},   16'(ifid_hold[s]),   16'(e.stall));
      check({e.tag, ".idex_bubble"}, 16'(idex_bubble[s]), 16'(e.stall));
      check({e.tag, ".ifid_flush"},  16'(ifid_flush[s]),  16'(e.flush));
      check({e.tag, ".idex_flush"},  16'(idex_flush[s]),  16'(e.flush));
      check({e.tag, ".freeze"},      16'(freeze[s]),      16'(e.frz));
      check({e.tag, ".stall_cycles"}, sc[s],              e.cnt);
    end
  end

  // Input kinds: 0 clear, 1 rs1 hazard, 2 rd=0/rs1=0, 3 rs2 match unused,
  // 4 rs2 hazard, 5 match without load.
  task automatic drive(input int kind, input logic br, input logic busy, input logic rst);
    rst_n           = rst;
    branch_taken_ex = br;
    mem_busy        = busy;
    memread_idex    = 1'b0;
    rd_idex         = '0;
    rs1_ifid        = '0;
    rs2_ifid        = '0;
    use_rs1         = 1'b0;
    use_rs2         = 1'b0;
    case (kind)
      1: begin memread_idex = 1'b1; rd_idex = 5'd5; rs1_ifid = 5'd5; use_rs1 = 1'b1; end
      2: begin memread_idex = 1'b1; use_rs1 = 1'b1; end
      3: begin memread_idex = 1'b1; rd_idex = 5'd5; rs2_ifid = 5'd5; rs1_ifid = 5'd5; end
      4: begin memread_idex = 1'b1; rd_idex = 5'd7; rs2_ifid = 5'd7; use_rs2 = 1'b1; end
      5: begin rd_idex = 5'd5; rs1_ifid = 5'd5; use_rs1 = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic step(input int sel, input string tag, input int kind, input logic br,
                      input logic busy, input logic rst, input logic stall,
                      input logic flush, input logic frz, input int cnt);
    exp_t e;
    @(posedge clk);
    #1;
    drive(kind, br, busy, rst);
    e.sel = sel; e.tag = tag; e.stall = stall; e.flush = flush; e.frz = frz;
    e.cnt = 16'(cnt);
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int sel);
    step(sel, "rst_hz",   1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    step(sel, "rst_busy", 1, 1'b1, 1'b1, 1'b0, 0, 0, 1, 0);
  endtask

  initial begin
    // LOAD_LAT=1 and operand-qualification cases
    do_reset(0);
    step(0, "l1_hz",      1, 0, 0, 1, 1, 0, 0, 0);
    step(0, "l1_after",   0, 0, 0, 1, 0, 0, 0, 1);
    step(0, "l1_rd0",     2, 0, 0, 1, 0, 0, 0, 1);
    step(0, "l1_rs2_off", 3, 0, 0, 1, 0, 0, 0, 1);
    step(0, "l1_rs2_hz",  4, 0, 0, 1, 1, 0, 0, 1);
    step(0, "l1_noload",  5, 0, 0, 1, 0, 0, 0, 2);

    // LOAD_LAT=3 exact length and back-to-back restart
    do_reset(1);
    step(1, "l3_c0",  1, 0, 0, 1, 1, 0, 0, 0);
    step(1, "l3_c1",  0, 0, 0, 1, 1, 0, 0, 1);
    step(1, "l3_c2",  0, 0, 0, 1, 1, 0, 0, 2);
    step(1, "l3_end", 0, 0, 0, 1, 0, 0, 0, 3);
    step(1, "l3_b0",  1, 0, 0, 1, 1, 0, 0, 3);
    step(1, "l3_b1",  0, 0, 0, 1, 1, 0, 0, 4);
    step(1, "l3_b2",  1, 0, 0, 1, 1, 0, 0, 5);
    step(1, "l3_re0", 1, 0, 0, 1, 1, 0, 0, 6);
    step(1, "l3_re1", 0, 0, 0, 1, 1, 0, 0, 7);
    step(1, "l3_re2", 0, 0, 0, 1, 1, 0, 0, 8);
    step(1, "l3_idle",0, 0, 0, 1, 0, 0, 0, 9);

    // LOAD_LAT=3 branch in the second stall cycle
    do_reset(1);
    step(1, "br_c0",    1, 0, 0, 1, 1, 0, 0, 0);
    step(1, "br_flush", 0, 1, 0, 1, 0, 1, 0, 1);
    step(1, "br_idle",  0, 0, 0, 1, 0, 0, 0, 1);
    step(1, "br_hz",    1, 1, 0, 1, 0, 1, 0, 1);
    step(1, "br_idle2", 0, 0, 0, 1, 0, 0, 0, 1);
    step(1, "br_busy",  1, 1, 1, 1, 0, 0, 1, 1);

    // LOAD_LAT=4 freeze mid-stall
    do_reset(2);
    step(2, "fz_c0",   1, 0, 0, 1, 1, 0, 0, 0);
    step(2, "fz_c1",   0, 0, 0, 1, 1, 0, 0, 1);
    step(2, "fz_f0",   0, 0, 1, 1, 0, 0, 1, 2);
    step(2, "fz_f1",   0, 0, 1, 1, 0, 0, 1, 2);
    step(2, "fz_c2",   0, 0, 0, 1, 1, 0, 0, 2);
    step(2, "fz_c3",   0, 0, 0, 1, 1, 0, 0, 3);
    step(2, "fz_idle", 0, 0, 0, 1, 0, 0, 0, 4);

    // CNT_W=4 saturation, then reset mid-stall
    do_reset(2);
    for (int k = 0; k < 21; k++)
      step(2, $sformatf("sat%0d", k), 1, 0, 0, 1, 1, 0, 0, (k > 15) ? 15 : k);
    step(2, "midrst",   0, 0, 0, 0, 0, 0, 0, 0);
    step(2, "post_rst", 0, 0, 0, 1, 0, 0, 0, 0);
    step(2, "post_idl", 0, 0, 0, 1, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL take parameter REG_W, default 5, as the register-address width.
REQ-002 The block SHALL take parameter LOAD_LAT, default 1, legal 1..7, as load-use stall cycles per hazard.
REQ-003 The block SHALL take parameter CNT_W, default 16, as the stall-statistic counter width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 rs1_ifid, rs2_ifid  in  REG_W each  source registers of the instruction in IF/ID.
REQ-007 use_rs1, use_rs2  in  1 each  source operand actually read by the IF/ID instruction.
REQ-008 rd_idex  in  REG_W  destination register of the instruction in ID/EX.
REQ-009 memread_idex  in  1  ID/EX instruction is a load.
REQ-010 branch_taken_ex  in  1  taken branch or jump resolved in EX this cycle.
REQ-011 mem_busy  in  1  data memory not ready; whole pipeline must freeze.
REQ-012 pc_stall  out  1  hold PC.
REQ-013 ifid_hold  out  1  hold IF/ID.
REQ-014 idex_bubble  out  1  zero ID/EX control signals (insert bubble).
REQ-015 ifid_flush, idex_flush  out  1 each  clear IF/ID and ID/EX to NOP.
REQ-016 freeze  out  1  hold every pipeline register.
REQ-017 stall_cycles  out  CNT_W  count of cycles with pc_stall=1.

Function
REQ-018 The block SHALL compute hz = memread_idex & (rd_idex!=0) & ((use_rs1 & rs1_ifid==rd_idex) | (use_rs2 & rs2_ifid==rd_idex)).
REQ-019 The FSM SHALL have two states, IDLE and STALL, plus a 3-bit down-counter cnt.
REQ-020 In IDLE with hz=1, branch_taken_ex=0 and mem_busy=0, the block SHALL assert pc_stall, ifid_hold and idex_bubble combinationally in that cycle.
REQ-021 On that IDLE hazard cycle, if LOAD_LAT>1 the block SHALL enter STALL with cnt=LOAD_LAT-1; otherwise it SHALL remain in IDLE.
REQ-022 In STALL, pc_stall, ifid_hold and idex_bubble SHALL be 1 regardless of hz; cnt SHALL decrement each non-frozen cycle, and at cnt==1 the next state SHALL be IDLE.
REQ-023 Total stall per hazard SHALL be exactly LOAD_LAT cycles when no freeze or flush intervenes.
REQ-024 In any state, branch_taken_ex=1 with mem_busy=0 SHALL assert ifid_flush and idex_flush, deassert pc_stall, ifid_hold and idex_bubble, and force the next state to IDLE with cnt=0.
REQ-025 mem_busy=1 SHALL assert freeze and force every other output to 0, and SHALL hold state and cnt unchanged; freeze overrides flush and stall.
REQ-026 Priority SHALL be mem_busy > branch_taken_ex > STALL state > hz.
REQ-027 A hazard detected in the cycle the FSM returns to IDLE SHALL start a new stall sequence.
REQ-028 stall_cycles SHALL increment by 1 on each rising edge where pc_stall=1, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-029 All outputs except stall_cycles SHALL be combinational from state, cnt and inputs; no output depends on prior-cycle inputs except through state.

Reset
REQ-030 rst_n=0 SHALL immediately set state=IDLE, cnt=0 and stall_cycles=0, independent of clk.
REQ-031 During reset, pc_stall, ifid_hold, idex_bubble, ifid_flush, idex_flush and freeze SHALL be 0, except freeze, which follows mem_busy.
REQ-032 Reset asserted mid-STALL SHALL abort the sequence; after release the block SHALL be in IDLE with no residual stall.

Verification
REQ-033 LOAD_LAT=1: memread_idex=1, rd_idex=5, rs1_ifid=5, use_rs1=1 -> one cycle with pc_stall=ifid_hold=idex_bubble=1, then 0; stall_cycles=1.
REQ-034 LOAD_LAT=3: same hazard, then inputs cleared -> stall for exactly 3 consecutive cycles; stall_cycles=3.
REQ-035 rd_idex=0 with rs1_ifid=0, or rs2 match with use_rs2=0 -> no stall.
REQ-036 LOAD_LAT=4 with mem_busy=1 for 2 cycles mid-STALL -> freeze=1 and other outputs 0 for those cycles; total pc_stall cycles still 4.
REQ-037 LOAD_LAT=3 with branch_taken_ex=1 in the 2nd stall cycle -> ifid_flush=idex_flush=1, pc_stall=0 that cycle, IDLE next; stall_cycles=1.
REQ-038 CNT_W=4 with 20 back-to-back hazards -> stall_cycles saturates at 15; rst_n pulse mid-STALL -> outputs 0 immediately and counter returns to 0.
